// File: rtl/ysyx_25060170_idu_stage.sv
// RV32I/RV32E decode stage: combinational decode of the offered instruction,
// captured into an output register with a one-entry skid buffer behind it.
module ysyx_25060170_idu_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [31:0]       inst_i,
  output logic [REG_AW-1:0] rs1_raddr_o,
  output logic [REG_AW-1:0] rs2_raddr_o,
  input  logic [XLEN-1:0]   reg1_rdata_i,
  input  logic [XLEN-1:0]   reg2_rdata_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   out_pc_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic [XLEN-1:0]   imm_o,
  output logic [XLEN-1:0]   op_1_o,
  output logic [XLEN-1:0]   op_2_o,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic [XLEN-1:0]   rs2_data_o,
  output logic [3:0]        ALUop_o,
  output logic [1:0]        regS_o,
  output logic [2:0]        funct3_o,
  output logic              RegW_o,
  output logic              MemWr_o,
  output logic              MemRd_o,
  output logic              branch_o,
  output logic              jal_o,
  output logic              PCx1_o,
  output logic              jump_en_o,
  output logic              illegal_o
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [XLEN-1:0]   rs1d;
    logic [XLEN-1:0]   rs2d;
    logic [REG_AW-1:0] rd;
    logic [3:0]        aluop;
    logic [1:0]        regs;
    logic [2:0]        funct3;
    logic              regw;
    logic              memwr;
    logic              memrd;
    logic              branch;
    logic              jal;
    logic              pcx1;
    logic              jump_en;
    logic              illegal;
  } bundle_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    sext32 = XLEN'($signed(v));
  endfunction

  function automatic logic [3:0] alu_base(input logic [2:0] f3);
    case (f3)
      3'b000:  alu_base = 4'd0;
      3'b001:  alu_base = 4'd2;
      3'b010:  alu_base = 4'd3;
      3'b011:  alu_base = 4'd4;
      3'b100:  alu_base = 4'd5;
      3'b101:  alu_base = 4'd6;
      3'b110:  alu_base = 4'd8;
      3'b111:  alu_base = 4'd9;
      default: alu_base = 4'd0;
    endcase
  endfunction

  logic [6:0]  opcode_s;
  logic [2:0]  f3_s;
  logic [6:0]  f7_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  logic        bad_s, rve_bad_s, use_rs1_s, use_rs2_s, use_rd_s;
  logic        accept_s, load_main_s, main_from_skid_s, load_skid_s;
  bundle_t     dec_s, main_r, skid_r;
  state_t      state_r, state_nxt_s;
  logic        in_ready_r, out_valid_r;

  assign opcode_s = inst_i[6:0];
  assign f3_s     = inst_i[14:12];
  assign f7_s     = inst_i[31:25];
  assign imm_i_s  = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s_s  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b_s  = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u_s  = {inst_i[31:12], 12'd0};
  assign imm_j_s  = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  assign rs1_raddr_o = inst_i[15 +: REG_AW];
  assign rs2_raddr_o = inst_i[20 +: REG_AW];

  // Instruction decode into a bundle, with illegal encodings squashed.
  always_comb begin
    dec_s        = '0;
    bad_s        = 1'b0;
    use_rs1_s    = 1'b0;
    use_rs2_s    = 1'b0;
    use_rd_s     = 1'b0;
    dec_s.pc     = pc_i;
    dec_s.rd     = inst_i[7 +: REG_AW];
    dec_s.rs1d   = reg1_rdata_i;
    dec_s.rs2d   = reg2_rdata_i;
    dec_s.funct3 = f3_s;
    case (opcode_s)
      OPC_OP: begin
        {use_rs1_s, use_rs2_s, use_rd_s} = 3'b111;
        dec_s.op1  = reg1_rdata_i;
        dec_s.op2  = reg2_rdata_i;
        dec_s.regw = 1'b1;
        if (inst_i[30] && (f3_s == 3'b000 || f3_s == 3'b101)) begin
          dec_s.aluop = alu_base(f3_s) + 4'd1;
        end else begin
          dec_s.aluop = alu_base(f3_s);
        end
        if (f7_s == 7'h00 || (f7_s == 7'h20 && (f3_s == 3'b000 || f3_s == 3'b101))) begin
          bad_s = 1'b0;
        end else begin
          bad_s = 1'b1;
        end
      end
      OPC_OPIMM: begin
        {use_rs1_s, use_rd_s} = 2'b11;
        dec_s.imm  = sext32(imm_i_s);
        dec_s.op1  = reg1_rdata_i;
        dec_s.op2  = sext32(imm_i_s);
        dec_s.regw = 1'b1;
        if (inst_i[30] && f3_s == 3'b101) begin
          dec_s.aluop = 4'd7;
        end else begin
          dec_s.aluop = alu_base(f3_s);
        end
      end
      OPC_LOAD: begin
        {use_rs1_s, use_rd_s} = 2'b11;
        dec_s.imm   = sext32(imm_i_s);
        dec_s.op1   = reg1_rdata_i;
        dec_s.op2   = sext32(imm_i_s);
        dec_s.regw  = 1'b1;
        dec_s.memrd = 1'b1;
        dec_s.regs  = 2'd1;
      end
      OPC_STORE: begin
        {use_rs1_s, use_rs2_s} = 2'b11;
        dec_s.imm   = sext32(imm_s_s);
        dec_s.op1   = reg1_rdata_i;
        dec_s.op2   = sext32(imm_s_s);
        dec_s.memwr = 1'b1;
      end
      OPC_LUI: begin
        use_rd_s    = 1'b1;
        dec_s.imm   = sext32(imm_u_s);
        dec_s.op2   = sext32(imm_u_s);
        dec_s.aluop = 4'd10;
        dec_s.regw  = 1'b1;
      end
      OPC_AUIPC: begin
        use_rd_s   = 1'b1;
        dec_s.imm  = sext32(imm_u_s);
        dec_s.op1  = pc_i;
        dec_s.op2  = sext32(imm_u_s);
        dec_s.regw = 1'b1;
        dec_s.regs = 2'd3;
      end
      OPC_BRANCH: begin
        {use_rs1_s, use_rs2_s} = 2'b11;
        dec_s.imm    = sext32(imm_b_s);
        dec_s.op1    = reg1_rdata_i;
        dec_s.op2    = reg2_rdata_i;
        dec_s.branch = 1'b1;
        case (f3_s)
          3'b100, 3'b101: dec_s.aluop = 4'd3;
          3'b110, 3'b111: dec_s.aluop = 4'd4;
          default:        dec_s.aluop = 4'd1;
        endcase
      end
      OPC_JAL: begin
        use_rd_s   = 1'b1;
        dec_s.imm  = sext32(imm_j_s);
        dec_s.op1  = pc_i;
        dec_s.op2  = XLEN'(32'd4);
        dec_s.jal  = 1'b1;
        dec_s.regw = 1'b1;
        dec_s.regs = 2'd2;
      end
      OPC_JALR: begin
        {use_rs1_s, use_rd_s} = 2'b11;
        dec_s.imm  = sext32(imm_i_s);
        dec_s.op1  = pc_i;
        dec_s.op2  = XLEN'(32'd4);
        dec_s.pcx1 = 1'b1;
        dec_s.regw = 1'b1;
        dec_s.regs = 2'd2;
      end
      default: bad_s = 1'b1;
    endcase
    // RV32E only has x0..x15, so bit 4 of any register index in use is illegal.
    rve_bad_s = (REG_AW < 5) &&
                ((use_rs1_s && inst_i[19]) || (use_rs2_s && inst_i[24]) || (use_rd_s && inst_i[11]));
    if (bad_s || rve_bad_s) begin
      dec_s.regw    = 1'b0;
      dec_s.memwr   = 1'b0;
      dec_s.memrd   = 1'b0;
      dec_s.branch  = 1'b0;
      dec_s.jal     = 1'b0;
      dec_s.pcx1    = 1'b0;
      dec_s.illegal = 1'b1;
    end else begin
      dec_s.illegal = 1'b0;
    end
    dec_s.jump_en = dec_s.jal | dec_s.pcx1;
  end

  assign accept_s = in_valid_i & in_ready_r & ~flush_i;

  // Main/skid occupancy state machine and register load enables.
  always_comb begin
    state_nxt_s      = state_r;
    load_main_s      = 1'b0;
    main_from_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (flush_i) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            load_main_s = 1'b1;
            state_nxt_s = ST_FULL;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (accept_s && out_ready_i) begin
            load_main_s = 1'b1;
            state_nxt_s = ST_FULL;
          end else if (accept_s) begin
            load_skid_s = 1'b1;
            state_nxt_s = ST_SKID;
          end else if (out_ready_i) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        ST_SKID: begin
          if (out_ready_i) begin
            load_main_s      = 1'b1;
            main_from_skid_s = 1'b1;
            state_nxt_s      = ST_FULL;
          end else begin
            state_nxt_s = ST_SKID;
          end
        end
        default: state_nxt_s = ST_EMPTY;
      endcase
    end
  end

  // State and handshake flags, registered so in_ready never sees out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s != ST_SKID);
      out_valid_r <= (state_nxt_s != ST_EMPTY);
    end
  end

  // Decoded bundle storage: main output register and skid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_r <= '0;
      skid_r <= '0;
    end else begin
      if (load_main_s) begin
        main_r <= main_from_skid_s ? skid_r : dec_s;
      end else begin
        main_r <= main_r;
      end
      if (load_skid_s) begin
        skid_r <= dec_s;
      end else begin
        skid_r <= skid_r;
      end
    end
  end

  assign in_ready_o  = in_ready_r;
  assign out_valid_o = out_valid_r;
  assign out_pc_o    = main_r.pc;
  assign rd_addr_o   = main_r.rd;
  assign imm_o       = main_r.imm;
  assign op_1_o      = main_r.op1;
  assign op_2_o      = main_r.op2;
  assign rs1_data_o  = main_r.rs1d;
  assign rs2_data_o  = main_r.rs2d;
  assign ALUop_o     = main_r.aluop;
  assign regS_o      = main_r.regs;
  assign funct3_o    = main_r.funct3;
  assign RegW_o      = main_r.regw;
  assign MemWr_o     = main_r.memwr;
  assign MemRd_o     = main_r.memrd;
  assign branch_o    = main_r.branch;
  assign jal_o       = main_r.jal;
  assign PCx1_o      = main_r.pcx1;
  assign jump_en_o   = main_r.jump_en;
  assign illegal_o   = main_r.illegal;

endmodule

// File: tb/tb_ysyx_25060170_idu_stage.sv
// Bench for the decode stage: an RV32I and an RV32E instance checked every cycle
// against a queue-based model, plus directed literal checks.
module tb_ysyx_25060170_idu_stage;

  typedef struct packed {
    logic [31:0] pc, imm, op1, op2, rs1d, rs2d;
    logic [4:0]  rd;
    logic [3:0]  aluop;
    logic [1:0]  regs;
    logic [2:0]  f3;
    logic        regw, memwr, memrd, branch, jal, pcx1, jump_en, illegal;
  } dec_t;

  logic        clk = 1'b0, rst_n = 1'b1, flush_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
  logic        out_ready_e = 1'b1;
  logic [31:0] pc_i = '0, inst_i = '0, reg1 = '0, reg2 = '0;

  logic        d_in_ready, d_out_valid, d_regw, d_memwr, d_memrd, d_branch, d_jal, d_pcx1, d_jump_en, d_illegal;
  logic [4:0]  d_rs1a, d_rs2a, d_rd;
  logic [31:0] d_pc, d_imm, d_op1, d_op2, d_rs1d, d_rs2d;
  logic [3:0]  d_aluop;
  logic [1:0]  d_regs;
  logic [2:0]  d_f3;

  logic        e_in_ready, e_out_valid, e_regw, e_memwr, e_memrd, e_branch, e_jal, e_pcx1, e_jump_en, e_illegal;
  logic [3:0]  e_rs1a, e_rs2a, e_rd;
  logic [31:0] e_pc, e_imm, e_op1, e_op2, e_rs1d, e_rs2d;
  logic [3:0]  e_aluop;
  logic [1:0]  e_regs;
  logic [2:0]  e_f3;

  ysyx_25060170_idu_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(d_in_ready),
    .pc_i(pc_i), .inst_i(inst_i), .rs1_raddr_o(d_rs1a), .rs2_raddr_o(d_rs2a),
    .reg1_rdata_i(reg1), .reg2_rdata_i(reg2), .out_valid_o(d_out_valid), .out_ready_i(out_ready_i),
    .out_pc_o(d_pc), .rd_addr_o(d_rd), .imm_o(d_imm), .op_1_o(d_op1), .op_2_o(d_op2),
    .rs1_data_o(d_rs1d), .rs2_data_o(d_rs2d), .ALUop_o(d_aluop), .regS_o(d_regs), .funct3_o(d_f3),
    .RegW_o(d_regw), .MemWr_o(d_memwr), .MemRd_o(d_memrd), .branch_o(d_branch), .jal_o(d_jal),
    .PCx1_o(d_pcx1), .jump_en_o(d_jump_en), .illegal_o(d_illegal));

  ysyx_25060170_idu_stage #(.XLEN(32), .REG_AW(4)) dut_e (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(e_in_ready),
    .pc_i(pc_i), .inst_i(inst_i), .rs1_raddr_o(e_rs1a), .rs2_raddr_o(e_rs2a),
    .reg1_rdata_i(reg1), .reg2_rdata_i(reg2), .out_valid_o(e_out_valid), .out_ready_i(out_ready_e),
    .out_pc_o(e_pc), .rd_addr_o(e_rd), .imm_o(e_imm), .op_1_o(e_op1), .op_2_o(e_op2),
    .rs1_data_o(e_rs1d), .rs2_data_o(e_rs2d), .ALUop_o(e_aluop), .regS_o(e_regs), .funct3_o(e_f3),
    .RegW_o(e_regw), .MemWr_o(e_memwr), .MemRd_o(e_memrd), .branch_o(e_branch), .jal_o(e_jal),
    .PCx1_o(e_pcx1), .jump_en_o(e_jump_en), .illegal_o(e_illegal));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  dec_t q5[$];
  dec_t q4[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic dec_t d_bundle();
    return '{d_pc, d_imm, d_op1, d_op2, d_rs1d, d_rs2d, d_rd, d_aluop, d_regs, d_f3,
             d_regw, d_memwr, d_memrd, d_branch, d_jal, d_pcx1, d_jump_en, d_illegal};
  endfunction

  function automatic dec_t e_bundle();
    return '{e_pc, e_imm, e_op1, e_op2, e_rs1d, e_rs2d, {1'b0, e_rd}, e_aluop, e_regs, e_f3,
             e_regw, e_memwr, e_memrd, e_branch, e_jal, e_pcx1, e_jump_en, e_illegal};
  endfunction

  // Reference decode written straight from the ISA field definitions.
  function automatic dec_t model_dec(input logic [31:0] i, input logic [31:0] pc,
                                     input logic [31:0] r1, input logic [31:0] r2, input bit rve);
    dec_t d;
    logic [31:0] sx, ii, si, bi, ui, ji;
    int alu_tab[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    bit bad, u1, u2, ud;
    d = '0; bad = 0; u1 = 0; u2 = 0; ud = 0;
    sx = 32'($signed(i) >>> 31);
    ii = 32'($signed(i) >>> 20);
    si = (ii & ~32'h1F) | {27'd0, i[11:7]};
    bi = (sx << 12) | ({31'd0, i[7]} << 11) | ({26'd0, i[30:25]} << 5) | ({28'd0, i[11:8]} << 1);
    ui = i & 32'hFFFFF000;
    ji = (sx << 20) | ({24'd0, i[19:12]} << 12) | ({31'd0, i[20]} << 11) | ({22'd0, i[30:21]} << 1);
    d.pc = pc; d.rs1d = r1; d.rs2d = r2; d.f3 = i[14:12];
    d.rd = rve ? {1'b0, i[10:7]} : i[11:7];
    case (i[6:0])
      7'h33: begin
        u1 = 1; u2 = 1; ud = 1; d.op1 = r1; d.op2 = r2; d.regw = 1;
        d.aluop = 4'(alu_tab[i[14:12]] + int'(i[30] && (i[14:12] == 3'd0 || i[14:12] == 3'd5)));
        bad = !(i[31:25] == 7'h00 || (i[31:25] == 7'h20 && (i[14:12] == 3'd0 || i[14:12] == 3'd5)));
      end
      7'h13: begin
        u1 = 1; ud = 1; d.imm = ii; d.op1 = r1; d.op2 = ii; d.regw = 1;
        d.aluop = 4'(alu_tab[i[14:12]] + int'(i[30] && i[14:12] == 3'd5));
      end
      7'h03: begin u1 = 1; ud = 1; d.imm = ii; d.op1 = r1; d.op2 = ii; d.regw = 1; d.memrd = 1; d.regs = 2'd1; end
      7'h23: begin u1 = 1; u2 = 1; d.imm = si; d.op1 = r1; d.op2 = si; d.memwr = 1; end
      7'h37: begin ud = 1; d.imm = ui; d.op2 = ui; d.aluop = 4'd10; d.regw = 1; end
      7'h17: begin ud = 1; d.imm = ui; d.op1 = pc; d.op2 = ui; d.regw = 1; d.regs = 2'd3; end
      7'h63: begin
        u1 = 1; u2 = 1; d.imm = bi; d.op1 = r1; d.op2 = r2; d.branch = 1;
        d.aluop = (i[14] == 1'b0) ? 4'd1 : (i[13] ? 4'd4 : 4'd3);
      end
      7'h6F: begin ud = 1; d.imm = ji; d.op1 = pc; d.op2 = 32'd4; d.jal = 1; d.regw = 1; d.regs = 2'd2; end
      7'h67: begin u1 = 1; ud = 1; d.imm = ii; d.op1 = pc; d.op2 = 32'd4; d.pcx1 = 1; d.regw = 1; d.regs = 2'd2; end
      default: bad = 1;
    endcase
    if (rve && ((u1 && i[19]) || (u2 && i[24]) || (ud && i[11]))) bad = 1;
    if (bad) begin
      d.regw = 0; d.memwr = 0; d.memrd = 0; d.branch = 0; d.jal = 0; d.pcx1 = 0; d.illegal = 1;
    end
    d.jump_en = d.jal | d.pcx1;
    return d;
  endfunction

  // Per-cycle scoreboard: two-entry queues per instance, flush/reset empty them.
  initial begin
    dec_t d5, d4;
    bit acc5, con5, acc4, con4;
    forever begin
      @(posedge clk);
      if (!rst_n || flush_i) begin
        q5.delete();
        q4.delete();
      end else begin
        d5 = model_dec(inst_i, pc_i, reg1, reg2, 1'b0);
        d4 = model_dec(inst_i, pc_i, reg1, reg2, 1'b1);
        acc5 = in_valid_i && (q5.size() < 2);
        con5 = (q5.size() > 0) && out_ready_i;
        acc4 = in_valid_i && (q4.size() < 2);
        con4 = (q4.size() > 0) && out_ready_e;
        if (con5) void'(q5.pop_front());
        if (acc5) q5.push_back(d5);
        if (con4) void'(q4.pop_front());
        if (acc4) q4.push_back(d4);
      end
      #1;
      if (rst_n) begin
        chk("in_ready", d_in_ready, q5.size() < 2);
        chk("out_valid", d_out_valid, q5.size() > 0);
        if (q5.size() > 0) chk("bundle", d_bundle(), q5[0]);
        chk("rs1_raddr", d_rs1a, inst_i[19:15]);
        chk("rs2_raddr", d_rs2a, inst_i[24:20]);
        chk("e_in_ready", e_in_ready, q4.size() < 2);
        chk("e_out_valid", e_out_valid, q4.size() > 0);
        if (q4.size() > 0) chk("e_bundle", e_bundle(), q4[0]);
        chk("e_rs1_raddr", e_rs1a, inst_i[18:15]);
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2);
    in_valid_i = v; inst_i = ins; pc_i = p; reg1 = r1; reg2 = r2;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h63, 7'h6F, 7'h67};
    logic [31:0] r;
    int sel;
    r = $urandom;
    sel = $urandom_range(0, 11);
    if (sel < 9) begin
      r[6:0] = ops[sel];
      if (sel == 0 && $urandom_range(0, 3) != 0) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    end
    return r;
  endfunction

  initial begin
    dec_t m;
    logic [31:0] bp_pc[3];
    int idx;
    logic rdy_prev;
    bp_pc = '{32'h2000, 32'h2004, 32'h2008};

    // model pinned to hand-decoded encodings
    m = model_dec(32'hFE20DCE3, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("model_bge_imm", m.imm, 32'hFFFFFFF8);
    m = model_dec(32'h00208833, 32'h0, 32'h0, 32'h0, 1'b1);
    chk("model_rve_illegal", m.illegal, 1'b1);

    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", d_out_valid, 1'b0);
    chk("rst_in_ready", d_in_ready, 1'b1);
    chk("rst_bundle", d_bundle(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready_i = 1'b1;

    drive(1'b1, 32'hFFF08293, 32'h1000, 32'd7, 32'd0);
    @(negedge clk);
    chk("addi_valid", d_out_valid, 1'b1);
    chk("addi_op1", d_op1, 32'd7);
    chk("addi_op2", d_op2, 32'hFFFFFFFF);
    chk("addi_imm", d_imm, 32'hFFFFFFFF);
    chk("addi_rd", d_rd, 5'd5);
    chk("addi_alu", d_aluop, 4'd0);
    chk("addi_regw", d_regw, 1'b1);
    chk("addi_regs", d_regs, 2'd0);

    drive(1'b1, 32'hFE20DCE3, 32'h1004, 32'd1, 32'd2);
    @(negedge clk);
    chk("bge_branch", d_branch, 1'b1);
    chk("bge_alu", d_aluop, 4'd3);
    chk("bge_f3", d_f3, 3'd5);
    chk("bge_imm", d_imm, 32'hFFFFFFF8);
    chk("bge_regw", d_regw, 1'b0);

    drive(1'b1, 32'h00C100E7, 32'h1008, 32'h100, 32'd0);
    @(negedge clk);
    chk("jalr_pcx1", d_pcx1, 1'b1);
    chk("jalr_jump_en", d_jump_en, 1'b1);
    chk("jalr_imm", d_imm, 32'd12);
    chk("jalr_op2", d_op2, 32'd4);
    chk("jalr_regs", d_regs, 2'd2);

    drive(1'b1, 32'h0000007F, 32'h100C, 32'd0, 32'd0);
    @(negedge clk);
    chk("opc7f_illegal", d_illegal, 1'b1);
    chk("opc7f_regw", d_regw, 1'b0);
    chk("opc7f_memwr", d_memwr, 1'b0);

    drive(1'b1, 32'h022081B3, 32'h1010, 32'd3, 32'd4);
    @(negedge clk);
    chk("f7_01_illegal", d_illegal, 1'b1);
    chk("f7_01_regw", d_regw, 1'b0);
    chk("f7_01_memwr", d_memwr, 1'b0);

    drive(1'b1, 32'h00208833, 32'h1014, 32'd3, 32'd4);
    @(negedge clk);
    chk("add_x16_rv32i_illegal", d_illegal, 1'b0);
    chk("add_x16_rv32e_illegal", e_illegal, 1'b1);
    chk("add_x16_rv32e_regw", e_regw, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);

    // backpressure: three offers against a stalled consumer
    out_ready_i = 1'b0;
    idx = 0;
    rdy_prev = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0 && rdy_prev) idx++;
      if (idx < 3) drive(1'b1, 32'h00100093 + (32'(idx) << 20), bp_pc[idx], 32'd9, 32'd8);
      rdy_prev = d_in_ready;
      @(negedge clk);
    end
    chk("bp_accepted", idx, 2);
    chk("bp_in_ready", d_in_ready, 1'b0);
    chk("bp_first_pc", d_pc, 32'h2000);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    out_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_second_pc", d_pc, 32'h2004);
    chk("bp_second_valid", d_out_valid, 1'b1);
    @(negedge clk);
    chk("bp_drained", d_out_valid, 1'b0);

    // flush while both entries are occupied, with an offer in the same cycle
    out_ready_i = 1'b0;
    drive(1'b1, 32'h00500113, 32'h3000, 32'd1, 32'd1);
    @(negedge clk);
    drive(1'b1, 32'h00600113, 32'h3004, 32'd1, 32'd1);
    @(negedge clk);
    chk("flush_pre_in_ready", d_in_ready, 1'b0);
    flush_i = 1'b1;
    drive(1'b1, 32'h00700113, 32'h3008, 32'd1, 32'd1);
    @(negedge clk);
    chk("flush_out_valid", d_out_valid, 1'b0);
    chk("flush_in_ready", d_in_ready, 1'b1);
    flush_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    out_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("flush_never_output", d_out_valid, 1'b0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      flush_i     = ($urandom_range(0, 31) == 0);
      out_ready_i = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 3) != 0, rand_inst(), $urandom, $urandom, $urandom);
      @(negedge clk);
    end

    // asynchronous reset with one entry held
    flush_i = 1'b0;
    out_ready_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    drive(1'b1, 32'h0000A0B7, 32'h4000, 32'd5, 32'd6);
    @(negedge clk);
    chk("rst_mid_pre_valid", d_out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", d_out_valid, 1'b0);
    chk("rst_mid_in_ready", d_in_ready, 1'b1);
    chk("rst_mid_bundle", d_bundle(), '0);
    chk("rst_mid_e_bundle", e_bundle(), '0);
    chk("rst_mid_illegal", d_illegal, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_after_valid", d_out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
